fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 13 +
 rtl/fifo_rd_stream_buf2.sv | 71 +++++++
 rtl/fifo_rd_stream.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
// Shared sizing for the FIFO-read-to-stream adapter: skid buffer depth,
// occupancy counter width and head/tail pointer width.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;
  localparam int PTR_W     = 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/fifo_rd_stream_buf2.sv
// stream_buf2
// Two-entry circular buffer with head/tail pointers and an occupancy count.
// A write and a read in the same cycle both take effect and leave the count
// unchanged. The caller guarantees no write when full and no read when empty.
//
// Ports:
//   clk, rst       clock, async active-high reset (pointers and count only)
//   wr_en, wr_data write one entry at the tail
//   rd_en          retire the head entry
//   rd_data        head entry (oldest)
//   stored         number of buffered entries (0..2)
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DIN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DIN_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DIN_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]     stored
);

  logic [DIN_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DIN_WIDTH-1:0] mem_d [BUF_DEPTH];
  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  cnt_t                 stored_q, stored_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    stored_d = stored_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   stored_d = stored_q + cnt_t'(1);
      2'b01:   stored_d = stored_q - cnt_t'(1);
      default: stored_d = stored_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stored_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      stored_q <= stored_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by stored_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign stored  = stored_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Turns a sync-FIFO read port (request, data one cycle later) into a
// valid/ready stream. A 2-entry buffer absorbs the response pipeline; a read
// is only requested when the buffer is guaranteed to have room for it.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   fifo_empty      FIFO empty flag
//   fifo_read_req   read request (combinational, includes m_tready)
//   fifo_rdata      FIFO read data, qualified by fifo_r_valid
//   fifo_r_valid    FIFO read data valid
//   m_tdata/m_tvalid/m_tready  output stream
//   err_unexp       sticky: read data arrived with no read in flight
//   m_tlast         (FIFO_RD_STREAM_TLAST_EN only) last beat of a PKT_LEN packet
//
// Build option: define FIFO_RD_STREAM_TLAST_EN to add PKT_LEN and m_tlast.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DIN_WIDTH = 16
`ifdef FIFO_RD_STREAM_TLAST_EN
  ,
  parameter int PKT_LEN   = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_read_req,
  input  logic [DIN_WIDTH-1:0] fifo_rdata,
  input  logic                 fifo_r_valid,
  output logic [DIN_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 err_unexp
`ifdef FIFO_RD_STREAM_TLAST_EN
  ,
  output logic                 m_tlast
`endif
);

  localparam logic [CNT_W:0] DEPTH_C = BUF_DEPTH[CNT_W:0];

  logic [CNT_W-1:0] stored;
  logic             inflight_q, inflight_d;
  logic             err_unexp_q, err_unexp_d;
  logic             pop;
  logic             wr_en;
  logic [CNT_W:0]   occ;

  // occ is the occupancy the buffer will have once this cycle's pop retires
  // and the in-flight response lands; a new request is safe while it is < 2.
  always_comb begin
    pop           = m_tvalid & m_tready;
    wr_en         = fifo_r_valid & inflight_q;
    occ           = {1'b0, stored} + {{CNT_W{1'b0}}, inflight_q}
                  - {{CNT_W{1'b0}}, pop};
    fifo_read_req = !rst && !fifo_empty && (occ < DEPTH_C);
    inflight_d    = fifo_read_req;
    err_unexp_d   = err_unexp_q | (fifo_r_valid & ~inflight_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  stream_buf2 #(
    .DIN_WIDTH (DIN_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (fifo_rdata),
    .rd_en   (pop),
    .rd_data (m_tdata),
    .stored  (stored)
  );

  assign m_tvalid  = (stored != '0);
  assign err_unexp = err_unexp_q;

`ifdef FIFO_RD_STREAM_TLAST_EN
  localparam int              BEAT_W    = $clog2(PKT_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign m_tlast = m_tvalid & (beat_cnt_q == LAST_BEAT);
`endif

endmodule
